// File: rtl/exec_guard_pkg.sv
// Shared types and constants for the W^X alias-guard sequencer.
package exec_guard_pkg;

  localparam int PAGE_SHIFT = 12;
  localparam int DEF_PPN_W  = 20;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CHECK = 2'd1,
    ST_FLUSH = 2'd2
  } state_e;

  // A tracked (executable) page blocks writes unless the pre-lock boot override applies.
  function automatic logic guard_allow(input logic hit, input logic override, input logic lock);
    return (!hit) || (override && !lock);
  endfunction

endpackage

// File: rtl/exec_guard_sched_ppn_fill_fifo.sv
// Synchronous FIFO holding executable ITLB-fill PPNs awaiting tracker insertion.
module ppn_fill_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 20
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] push_data_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic         full_o,
  output logic         empty_o,
  output logic [W-1:0] head_o
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic [AW-1:0] wr_idx_s;
  logic          do_push_s;

  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign empty_o   = (count_q == '0);
  assign head_o    = mem_q[rd_ptr_q];
  assign do_push_s = push_i && !full_o;
  // A push in the flush cycle lands after the reset, so it is written at slot 0.
  assign wr_idx_s  = flush_i ? '0 : wr_ptr_q;

  // Pointer and occupancy next-state.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else if (pop_i && !empty_o) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
      count_d  = count_q - 1'b1;
    end else begin
      count_d  = count_q;
    end
    if (do_push_s) begin
      wr_ptr_d = wr_idx_s + 1'b1;
      count_d  = count_d + 1'b1;
    end else begin
      wr_ptr_d = wr_ptr_d;
    end
  end

  // Pointer registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage array; contents are don't-care while the pointers say empty.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_idx_s] <= push_data_i;
    end
  end

endmodule

// File: rtl/exec_guard_sched.sv
// Shares the exec_ppn_tracker port between ITLB fill inserts, sfence flushes
// and store W^X checks, and applies the alias-guard allow rule.
module exec_guard_sched
  import exec_guard_pkg::*;
#(
  parameter int PPN_W      = DEF_PPN_W,
  parameter int FILL_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  fill_valid,
  output logic                  fill_ready,
  input  logic                  fill_x,
  input  logic [PPN_W-1:0]      fill_ppn,
  input  logic                  sfence_req,
  input  logic                  sfence_global,
  output logic                  sfence_ack,
  input  logic                  st_valid,
  output logic                  st_ready,
  input  logic [PPN_W+11:0]     st_addr,
  output logic                  st_resp_valid,
  output logic                  st_resp_allow,
  input  logic                  lock_i,
  input  logic                  allow_override_prelock,
  output logic                  trk_clear,
  output logic                  trk_insert,
  output logic [PPN_W-1:0]      trk_insert_ppn,
  output logic [PPN_W+11:0]     trk_query_pa,
  input  logic                  trk_hit,
  output logic [CNT_W-1:0]      blocked_cnt
);

  state_e             state_q, state_d;
  logic               glob_q, glob_d;
  logic [PPN_W+11:0]  query_q, query_d;
  logic               resp_valid_q, resp_valid_d;
  logic               resp_allow_q, resp_allow_d;
  logic               clear_q, clear_d;
  logic               insert_q, insert_d;
  logic [PPN_W-1:0]   insert_ppn_q, insert_ppn_d;
  logic               ack_q, ack_d;
  logic [CNT_W-1:0]   blocked_q, blocked_d;

  logic               fifo_full_s, fifo_empty_s, fifo_push_s, fifo_pop_s, fifo_flush_s;
  logic [PPN_W-1:0]   fifo_head_s;
  logic               st_ready_s, allow_s;

  assign fill_ready  = !fifo_full_s;
  // Non-executable fills are handshaken but never reach the tracker.
  assign fifo_push_s = fill_valid && !fifo_full_s && fill_x;
  assign st_ready    = st_ready_s;
  assign allow_s     = guard_allow(trk_hit, allow_override_prelock, lock_i);

  ppn_fill_fifo #(
    .DEPTH (FILL_DEPTH),
    .W     (PPN_W)
  ) u_fill_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (fifo_push_s),
    .push_data_i (fill_ppn),
    .pop_i       (fifo_pop_s),
    .flush_i     (fifo_flush_s),
    .full_o      (fifo_full_s),
    .empty_o     (fifo_empty_s),
    .head_o      (fifo_head_s)
  );

  // Next-state and next-output logic for the IDLE/CHECK/FLUSH sequencer.
  always_comb begin
    state_d      = state_q;
    glob_d       = glob_q;
    query_d      = query_q;
    resp_valid_d = 1'b0;
    resp_allow_d = 1'b0;
    clear_d      = 1'b0;
    insert_d     = 1'b0;
    insert_ppn_d = insert_ppn_q;
    ack_d        = 1'b0;
    blocked_d    = blocked_q;
    fifo_pop_s   = 1'b0;
    fifo_flush_s = 1'b0;
    st_ready_s   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        st_ready_s = fifo_empty_s && !sfence_req;
        // Flush pulses are issued on entry so they appear in the FLUSH cycle.
        if (sfence_req) begin
          state_d = ST_FLUSH;
          glob_d  = sfence_global;
          ack_d   = 1'b1;
          clear_d = sfence_global;
        end else if (!fifo_empty_s) begin
          fifo_pop_s   = 1'b1;
          insert_d     = 1'b1;
          insert_ppn_d = fifo_head_s;
        end else if (st_valid) begin
          query_d = st_addr;
          state_d = ST_CHECK;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CHECK: begin
        resp_valid_d = 1'b1;
        resp_allow_d = allow_s;
        state_d      = ST_IDLE;
        if (!allow_s && (blocked_q != {CNT_W{1'b1}})) begin
          blocked_d = blocked_q + 1'b1;
        end else begin
          blocked_d = blocked_q;
        end
      end
      ST_FLUSH: begin
        // Only a global flush may drop queued executable pages.
        fifo_flush_s = glob_q;
        state_d      = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and registered-output flops.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      glob_q       <= 1'b0;
      query_q      <= '0;
      resp_valid_q <= 1'b0;
      resp_allow_q <= 1'b0;
      clear_q      <= 1'b0;
      insert_q     <= 1'b0;
      insert_ppn_q <= '0;
      ack_q        <= 1'b0;
      blocked_q    <= '0;
    end else begin
      state_q      <= state_d;
      glob_q       <= glob_d;
      query_q      <= query_d;
      resp_valid_q <= resp_valid_d;
      resp_allow_q <= resp_allow_d;
      clear_q      <= clear_d;
      insert_q     <= insert_d;
      insert_ppn_q <= insert_ppn_d;
      ack_q        <= ack_d;
      blocked_q    <= blocked_d;
    end
  end

  assign sfence_ack     = ack_q;
  assign st_resp_valid  = resp_valid_q;
  assign st_resp_allow  = resp_allow_q;
  assign trk_clear      = clear_q;
  assign trk_insert     = insert_q;
  assign trk_insert_ppn = insert_ppn_q;
  assign trk_query_pa   = query_q;
  assign blocked_cnt    = blocked_q;

endmodule

// File: tb/tb_exec_guard_sched.sv
// Directed, table-driven bench for exec_guard_sched with a behavioural tracker model.
module tb_exec_guard_sched;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fill_valid = 1'b0, fill_ready, fill_x = 1'b0;
  logic [19:0] fill_ppn = 20'h0;
  logic        sfence_req = 1'b0, sfence_global = 1'b0, sfence_ack;
  logic        st_valid = 1'b0, st_ready;
  logic [31:0] st_addr = 32'h0;
  logic        st_resp_valid, st_resp_allow;
  logic        lock_i = 1'b0, allow_override_prelock = 1'b0;
  logic        trk_clear, trk_insert;
  logic [19:0] trk_insert_ppn;
  logic [31:0] trk_query_pa;
  logic        trk_hit;
  logic [15:0] blocked_cnt;

  // Second instance with a narrow counter for the saturation check.
  logic        rst2 = 1'b1;
  logic        s_fill_ready, s_sfence_ack, s_st_ready, s_resp_valid, s_resp_allow;
  logic        s_trk_clear, s_trk_insert;
  logic [19:0] s_trk_insert_ppn;
  logic [31:0] s_trk_query_pa;
  logic [3:0]  s_blocked_cnt;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  exec_guard_sched #(.PPN_W(20), .FILL_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst),
    .fill_valid(fill_valid), .fill_ready(fill_ready), .fill_x(fill_x), .fill_ppn(fill_ppn),
    .sfence_req(sfence_req), .sfence_global(sfence_global), .sfence_ack(sfence_ack),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr),
    .st_resp_valid(st_resp_valid), .st_resp_allow(st_resp_allow),
    .lock_i(lock_i), .allow_override_prelock(allow_override_prelock),
    .trk_clear(trk_clear), .trk_insert(trk_insert), .trk_insert_ppn(trk_insert_ppn),
    .trk_query_pa(trk_query_pa), .trk_hit(trk_hit), .blocked_cnt(blocked_cnt)
  );

  exec_guard_sched #(.PPN_W(20), .FILL_DEPTH(4), .CNT_W(4)) dut_sat (
    .clk(clk), .rst(rst2),
    .fill_valid(1'b0), .fill_ready(s_fill_ready), .fill_x(1'b0), .fill_ppn(20'h0),
    .sfence_req(1'b0), .sfence_global(1'b0), .sfence_ack(s_sfence_ack),
    .st_valid(1'b1), .st_ready(s_st_ready), .st_addr(32'h0800_4000),
    .st_resp_valid(s_resp_valid), .st_resp_allow(s_resp_allow),
    .lock_i(1'b1), .allow_override_prelock(1'b0),
    .trk_clear(s_trk_clear), .trk_insert(s_trk_insert), .trk_insert_ppn(s_trk_insert_ppn),
    .trk_query_pa(s_trk_query_pa), .trk_hit(1'b1), .blocked_cnt(s_blocked_cnt)
  );

  // Behavioural exec_ppn_tracker: small set of PPNs, combinational hit.
  logic [19:0] tm_ppn [8];
  logic [7:0]  tm_v;
  logic [2:0]  tm_wp;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      tm_v  <= 8'h0;
      tm_wp <= 3'd0;
    end else if (trk_clear) begin
      tm_v  <= 8'h0;
    end else if (trk_insert) begin
      tm_ppn[tm_wp] <= trk_insert_ppn;
      tm_v[tm_wp]   <= 1'b1;
      tm_wp         <= tm_wp + 3'd1;
    end
  end

  always_comb begin
    trk_hit = 1'b0;
    for (int k = 0; k < 8; k++)
      if (tm_v[k] && (tm_ppn[k] == trk_query_pa[31:12])) trk_hit = 1'b1;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout_fail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out waiting for DUT", name);
  endtask

  // Present one store and check the two-cycle response; entered and left just after a negedge.
  task automatic do_store(input string name, input logic [31:0] addr, input logic ovr,
                          input logic lock, input logic exp_allow, input logic [15:0] exp_cnt);
    int i;
    allow_override_prelock = ovr;
    lock_i = lock;
    #1;
    for (i = 0; i < 50 && !st_ready; i++) @(negedge clk);
    if (!st_ready) begin
      timeout_fail({name, "_ready"});
      return;
    end
    st_valid = 1'b1;
    st_addr  = addr;
    @(posedge clk);
    @(negedge clk);
    st_valid = 1'b0;
    chk({name, "_early_resp"}, {31'h0, st_resp_valid}, 32'h0);
    chk({name, "_query_pa"}, trk_query_pa, addr);
    @(negedge clk);
    chk({name, "_resp_valid"}, {31'h0, st_resp_valid}, 32'h1);
    chk({name, "_allow"}, {31'h0, st_resp_allow}, {31'h0, exp_allow});
    chk({name, "_blocked"}, {16'h0, blocked_cnt}, {16'h0, exp_cnt});
  endtask

  task automatic do_fill(input string name, input logic [19:0] ppn, input logic x);
    chk({name, "_fill_ready"}, {31'h0, fill_ready}, 32'h1);
    fill_valid = 1'b1;
    fill_x     = x;
    fill_ppn   = ppn;
    @(posedge clk);
    @(negedge clk);
    fill_valid = 1'b0;
    if (x) begin
      chk({name, "_st_ready_blocked"}, {31'h0, st_ready}, 32'h0);
      @(negedge clk);
      chk({name, "_insert"}, {31'h0, trk_insert}, 32'h1);
      chk({name, "_insert_ppn"}, {12'h0, trk_insert_ppn}, {12'h0, ppn});
    end else begin
      chk({name, "_no_insert"}, {31'h0, trk_insert}, 32'h0);
    end
    chk({name, "_st_ready"}, {31'h0, st_ready}, 32'h1);
  endtask

  task automatic do_sfence(input string name, input logic glob);
    sfence_req    = 1'b1;
    sfence_global = glob;
    #1;
    chk({name, "_st_ready"}, {31'h0, st_ready}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk({name, "_ack"}, {31'h0, sfence_ack}, 32'h1);
    chk({name, "_clear"}, {31'h0, trk_clear}, {31'h0, glob});
    sfence_req = 1'b0;
    @(negedge clk);
    chk({name, "_ack_pulse"}, {31'h0, sfence_ack}, 32'h0);
    chk({name, "_clear_pulse"}, {31'h0, trk_clear}, 32'h0);
  endtask

  typedef struct {
    logic [2:0]  pre;        // 0 none, 1 fill x=1, 2 fill x=0, 3 local sfence, 4 global sfence
    logic [19:0] pre_ppn;
    logic [31:0] addr;
    logic        ovr;
    logic        lock;
    logic        exp_allow;
    logic [15:0] exp_cnt;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int ins;
    int k;
    int nr;
    vecs[0] = '{3'd0, 20'h00000, 32'h0800_4000, 1'b0, 1'b0, 1'b1, 16'd0};
    vecs[1] = '{3'd1, 20'h08004, 32'h0800_4010, 1'b0, 1'b0, 1'b0, 16'd1};
    vecs[2] = '{3'd0, 20'h00000, 32'h0800_4020, 1'b1, 1'b0, 1'b1, 16'd1};
    vecs[3] = '{3'd0, 20'h00000, 32'h0800_4030, 1'b1, 1'b1, 1'b0, 16'd2};
    vecs[4] = '{3'd2, 20'h11111, 32'h1111_1000, 1'b0, 1'b0, 1'b1, 16'd2};
    vecs[5] = '{3'd3, 20'h00000, 32'h0800_4040, 1'b0, 1'b0, 1'b0, 16'd3};
    vecs[6] = '{3'd4, 20'h00000, 32'h0800_4050, 1'b0, 1'b0, 1'b1, 16'd3};
    vecs[7] = '{3'd0, 20'h00000, 32'h0800_4060, 1'b0, 1'b1, 1'b1, 16'd3};

    repeat (3) @(negedge clk);
    chk("rst_resp_valid", {31'h0, st_resp_valid}, 32'h0);
    chk("rst_resp_allow", {31'h0, st_resp_allow}, 32'h0);
    chk("rst_ack", {31'h0, sfence_ack}, 32'h0);
    chk("rst_clear", {31'h0, trk_clear}, 32'h0);
    chk("rst_insert", {31'h0, trk_insert}, 32'h0);
    chk("rst_query_pa", trk_query_pa, 32'h0);
    chk("rst_blocked", {16'h0, blocked_cnt}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_fill_ready", {31'h0, fill_ready}, 32'h1);
    chk("rst_st_ready", {31'h0, st_ready}, 32'h1);

    for (int i = 0; i < 8; i++) begin
      case (vecs[i].pre)
        3'd1:    do_fill($sformatf("v%0d", i), vecs[i].pre_ppn, 1'b1);
        3'd2:    do_fill($sformatf("v%0d", i), vecs[i].pre_ppn, 1'b0);
        3'd3:    do_sfence($sformatf("v%0d_local", i), 1'b0);
        3'd4:    do_sfence($sformatf("v%0d_global", i), 1'b1);
        default: ;
      endcase
      do_store($sformatf("v%0d", i), vecs[i].addr, vecs[i].ovr, vecs[i].lock,
               vecs[i].exp_allow, vecs[i].exp_cnt);
    end

    // Hold a local sfence so nothing drains, fill the buffer, then offer a fifth fill and a store.
    allow_override_prelock = 1'b0;
    lock_i = 1'b0;
    sfence_req = 1'b1;
    sfence_global = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("full_fill%0d_ready", i), {31'h0, fill_ready}, 32'h1);
      fill_valid = 1'b1;
      fill_x = 1'b1;
      fill_ppn = 20'h0A000 + 20'(i);
      @(posedge clk);
      @(negedge clk);
    end
    fill_ppn = 20'h0A004;
    st_valid = 1'b1;
    st_addr  = 32'h0A00_3000;
    #1;
    chk("full_fifth_ready", {31'h0, fill_ready}, 32'h0);
    chk("full_st_ready", {31'h0, st_ready}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    fill_valid = 1'b0;
    for (k = 0; k < 10 && !sfence_ack; k++) @(negedge clk);
    if (!sfence_ack) timeout_fail("full_sfence_ack");
    sfence_req = 1'b0;
    ins = 0;
    for (k = 0; k < 20; k++) begin
      if (trk_insert) ins++;
      if (st_ready) break;
      @(negedge clk);
    end
    if (!st_ready) timeout_fail("full_store_wait");
    chk("full_inserts_before_store", ins, 32'd4);
    chk("full_last_insert_ppn", {12'h0, trk_insert_ppn}, 32'h0A003);
    @(posedge clk);
    @(negedge clk);
    st_valid = 1'b0;
    @(negedge clk);
    chk("full_store_valid", {31'h0, st_resp_valid}, 32'h1);
    chk("full_store_allow", {31'h0, st_resp_allow}, 32'h0);
    chk("full_store_blocked", {16'h0, blocked_cnt}, 32'd4);
    do_store("fifth_dropped", 32'h0A00_4000, 1'b0, 1'b0, 1'b1, 16'd4);

    // Reset while a store is in CHECK.
    st_valid = 1'b1;
    st_addr  = 32'h0A00_0000;
    #1;
    chk("rstchk_ready", {31'h0, st_ready}, 32'h1);
    @(posedge clk);
    @(negedge clk);
    st_valid = 1'b0;
    rst = 1'b1;
    #1;
    chk("rstchk_query_pa", trk_query_pa, 32'h0);
    chk("rstchk_blocked", {16'h0, blocked_cnt}, 32'h0);
    chk("rstchk_insert_ppn", {12'h0, trk_insert_ppn}, 32'h0);
    @(posedge clk);
    @(negedge clk);
    chk("rstchk_no_resp", {31'h0, st_resp_valid}, 32'h0);
    chk("rstchk_allow", {31'h0, st_resp_allow}, 32'h0);
    rst = 1'b0;
    @(negedge clk);
    do_store("post_rst", 32'h0A00_0000, 1'b0, 1'b0, 1'b1, 16'd0);

    // Saturation on the narrow-counter instance: every store denied.
    rst2 = 1'b0;
    nr = 0;
    for (k = 0; k < 200 && nr < 20; k++) begin
      @(negedge clk);
      if (s_resp_valid) begin
        nr++;
        chk($sformatf("sat_allow%0d", nr), {31'h0, s_resp_allow}, 32'h0);
        chk($sformatf("sat_cnt%0d", nr), {28'h0, s_blocked_cnt}, (nr > 15) ? 32'd15 : 32'(nr));
      end
    end
    if (nr < 20) timeout_fail("sat_responses");

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

endmodule
